uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (byte-level valid/ready input, e.g. the tx side inside uart_top) between NUM_REQ requesters.
- Grants the byte stream to one requester per packet. A packet is a byte run ending with req_last asserted.
- Arbitration is round-robin, so packets from different requesters never interleave on ser_tx.
- Sits between on-chip message sources (debug printers, status reporters) and the transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 255, stall cycles before a held lock is revoked (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i ends its packet.
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle when valid & ready.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts byte this cycle.
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  high in LOCKED.

Behaviour:
- Reset (async, any time including mid-packet) forces:
  - state=IDLE, grant=0, busy=0, tx_valid=0, req_ready=0, tx_data=0.
  - last_owner=NUM_REQ-1, so requester 0 has first priority.
  - Any partially sent packet is abandoned; no byte is replayed.
- FSM IDLE:
  - tx_valid=0, req_ready=0.
  - If any req_valid: pick the first requester with req_valid set, scanning from last_owner+1 upward mod NUM_REQ.
  - Register owner and grant; enter LOCKED next cycle. Arbitration latency is exactly 1 cycle.
- FSM LOCKED:
  - tx_valid = req_valid[owner]; tx_data = req_data[owner] (combinational mux on owner).
  - req_ready[owner] = tx_ready; all other req_ready bits = 0.
  - A transfer is req_valid[owner] & tx_ready.
  - Transfer with req_last[owner]=1: next cycle IDLE, last_owner=owner, grant=0.
  - Transfer without req_last: stay LOCKED.
  - Owner deasserting valid mid-packet keeps the lock; tx_valid drops, nothing is lost.
- Other requesters are ignored while LOCKED, regardless of their valid.
- Consecutive packets always pass through one IDLE bubble cycle, including same-owner back-to-back packets.
- Single-byte packet (first byte has last=1): LOCKED for exactly one transfer cycle.
- A packet from a requester is never split by arbitration.
- With several requesters valid continuously, each gets one packet per round in index order after the previous owner.
- req_last is sampled only on transfer cycles.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro:
  - stall_cnt (width clog2(TIMEOUT+1)) clears on entering LOCKED and on every transfer.
  - It increments on each LOCKED cycle with no transfer.
  - When stall_cnt==TIMEOUT and no transfer occurs that cycle, go to IDLE next cycle with last_owner=owner. The packet is truncated.
  - A transfer in the same cycle as reaching TIMEOUT wins: lock kept, counter cleared.
  - Also adds output port timeout_pulse (1 bit): high for exactly the one cycle in which the revoke is registered.
- Without the macro: no counter and no timeout_pulse port; the lock is held indefinitely until a last byte transfers.

Decomposition:
- Package uart_arb_pkg holds:
  - typedef enum {IDLE, LOCKED} arb_state_t;
  - localparam default NUM_REQ;
  - function idx_w(n) returning clog2 width.
- Sub-module uart_rr_picker: combinational (req vector, last_owner) -> (found, idx, onehot). Reused by other shared-resource arbiters.

Test Plan:
- Only req 2 sends 3-byte packet 0x41,0x42,0x0A (last on 0x0A), tx_ready=1 → grant=4'b0100 one cycle after valid; tx_data 41,42,0A on consecutive cycles; busy falls the cycle after 0x0A.
- Reqs 0,1,3 all valid with 2-byte packets from reset → packet order 0,1,3, then 0 again if still valid; one idle cycle between packets; no interleaved bytes.
- tx_ready toggles 1,0,0,1 during a 4-byte packet from req 1 → each byte held stable on tx_data while tx_ready=0; req_ready[1] mirrors tx_ready; all 4 bytes delivered in order.
- Owner drops valid for 10 cycles mid-packet while req 0 is valid → grant unchanged, tx_valid=0 for 10 cycles, req_ready[0]=0; packet then resumes.
- Assert rst for 1 cycle mid-packet → grant=0, tx_valid=0 immediately (async); after release, requester 0 wins first if valid.
- With UART_ARB_TIMEOUT_EN, TIMEOUT=5, owner stalls → timeout_pulse high once, exactly 5 stall cycles after the last transfer; next valid requester granted 1 cycle later.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its picker.
package uart_arb_pkg;

  // Arbiter state: IDLE looks for a new owner, LOCKED streams one packet.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_NUM_REQ = 4;

  // Width of an index able to address n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: finds the first set request scanning
// upward from last_owner+1, wrapping modulo N. Shared by other arbiters.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N = DEFAULT_NUM_REQ
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   last_owner,
  output logic                  found,
  output logic [idx_w(N)-1:0]   idx,
  output logic [N-1:0]          onehot
);

  localparam int IW = idx_w(N);

  // Scan offsets 1..N after last_owner; the first request hit wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == ((int'(last_owner) + k) % N))) begin
          found     = 1'b1;
          idx       = IW'(j);
          onehot[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one byte-wide UART transmitter
// between NUM_REQ requesters. A packet is a byte run ending with req_last;
// once granted, a requester keeps the transmitter until its last byte moves.
// Optional macro UART_ARB_TIMEOUT_EN adds a stall watchdog that revokes a lock
// after TIMEOUT idle cycles and exposes a timeout_pulse output.
//
// Handshake: a byte moves on a cycle where valid and ready are both high.
// Valid is never conditioned on ready; ready may depend on valid-free state
// only. req_ready[owner] mirrors tx_ready, tx_valid mirrors req_valid[owner].
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_pulse
`endif
);

  localparam int IW = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_t          state;
  logic [IW-1:0]       owner;
  logic [IW-1:0]       last_owner;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                locked;
  logic                own_valid;
  logic                own_last;
  logic [7:0]          own_data;
  logic                xfer;
  logic                stall_expired;

  uart_rr_picker #(
    .N(NUM_REQ)
  ) u_picker (
    .req        (req_valid),
    .last_owner (last_owner),
    .found      (pick_found),
    .idx        (pick_idx),
    .onehot     (pick_onehot)
  );

  // Route the current owner's valid, last flag and byte.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*8 +: 8];
      end
    end
  end

  assign locked    = (state == LOCKED);
  assign xfer      = locked && own_valid && tx_ready;
  assign busy      = locked;
  assign tx_valid  = locked && own_valid;
  assign tx_data   = locked ? own_data : 8'h00;
  assign req_ready = locked ? (grant & {NUM_REQ{tx_ready}}) : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt;

  assign stall_expired = locked && !xfer && (stall_cnt == CW'(TIMEOUT));
  assign timeout_pulse = stall_expired;

  // Count consecutive LOCKED cycles without a transfer; held at zero in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!locked || xfer) begin
      stall_cnt <= '0;
    end else if (stall_cnt != CW'(TIMEOUT)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_expired = 1'b0;
`endif

  // Arbitration FSM: pick an owner in IDLE, release it after its last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      grant      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            state <= LOCKED;
            owner <= pick_idx;
            grant <= pick_onehot;
          end
        end
        LOCKED: begin
          if ((xfer && own_last) || stall_expired) begin
            state      <= IDLE;
            last_owner <= owner;
            grant      <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester source queues, a scoreboard of
// expected {last, grant, byte} words, and directed plus randomized packets.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int W  = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*8-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [NR-1:0]     grant;
  logic              busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic              timeout_pulse;
`endif

  logic [W-1:0]      exp_q[$];
  logic [8:0]        src_q[NR][$];
  logic [NR-1:0]     en;
  logic [NR-1:0]     acc;
  logic              ready_val;
  logic              rnd_ready;
  logic              bubble_due;
  int                n_checks;
  int                n_errors;

`ifdef UART_ARB_TIMEOUT_EN
  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(5)) dut (
`else
  uart_tx_arbiter #(.NUM_REQ(NR)) dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp_v);
    end
  endtask

  // Queue one byte at requester r and record what the transmitter must see.
  task automatic send(input int r, input logic [7:0] b, input logic last);
    logic [NR-1:0] oh;
    oh = NR'(1) << r;
    src_q[r].push_back({last, b});
    exp_q.push_back({last, oh, b});
  endtask

  // One cycle: retire accepted bytes, drive inputs, then sample and score.
  task automatic step();
    logic [8:0]   hd;
    logic [W-1:0] e;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    acc = '0;
    for (int i = 0; i < NR; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        hd = src_q[i][0];
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = hd[7:0];
        req_last[i]         = hd[8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
    #1;
    if (bubble_due) begin
      check("bubble_busy", busy, 0);
      bubble_due = 1'b0;
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {grant, tx_data}, 12'h000);
      end else begin
        e = exp_q.pop_front();
        check("byte", {grant, tx_data}, e[11:0]);
        if (e[12]) bubble_due = 1'b1;
      end
    end
    for (int i = 0; i < NR; i++) acc[i] = req_valid[i] & req_ready[i];
  endtask

  function automatic bit src_pending();
    bit p = 1'b0;
    for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // Step until every queued byte has been delivered and the arbiter is idle.
  task automatic drain(input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while ((exp_q.size() > 0 || src_pending() || busy) && n < max);
    check("drain_pending", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    acc        = '0;
    bubble_due = 1'b0;
  endtask

  initial begin
    int len;
    int r;
    int k;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    tx_ready   = 1'b0;
    en         = '1;
    acc        = '0;
    ready_val  = 1'b1;
    rnd_ready  = 1'b0;
    bubble_due = 1'b0;
    n_checks   = 0;
    n_errors   = 0;

    // Reset state
    @(negedge clk);
    #1;
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_tx_data", tx_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester, 3-byte packet
    send(2, 8'h41, 1'b0);
    send(2, 8'h42, 1'b0);
    send(2, 8'h0A, 1'b1);
    step();
    check("t1_grant_idle", grant, 0);
    step();
    check("t1_grant", grant, 4'b0100);
    check("t1_busy", busy, 1);
    step();
    step();
    step();
    check("t1_busy_fall", busy, 0);
    drain(10);

    // Three requesters contending from reset: order 0,1,3 then 0 again
    do_reset();
    send(0, 8'hA0, 1'b0);
    send(0, 8'hA1, 1'b1);
    send(1, 8'hC0, 1'b0);
    send(1, 8'hC1, 1'b1);
    send(3, 8'hD0, 1'b0);
    send(3, 8'hD1, 1'b1);
    send(0, 8'hB0, 1'b0);
    send(0, 8'hB1, 1'b1);
    drain(60);

    // Backpressure 1,0,0,1 on a 4-byte packet from requester 1
    send(1, 8'h11, 1'b0);
    send(1, 8'h22, 1'b0);
    send(1, 8'h33, 1'b0);
    send(1, 8'h44, 1'b1);
    ready_val = 1'b1;
    step();
    step();
    check("t3_rdy_hi", req_ready, 4'b0010);
    ready_val = 1'b0;
    step();
    check("t3_hold_a", tx_data, 8'h22);
    check("t3_valid_a", tx_valid, 1);
    check("t3_rdy_lo_a", req_ready, 0);
    step();
    check("t3_hold_b", tx_data, 8'h22);
    check("t3_rdy_lo_b", req_ready, 0);
    ready_val = 1'b1;
    step();
    check("t3_rdy_hi_b", req_ready, 4'b0010);
    drain(20);

    // Owner 3 pauses 10 cycles mid-packet while requester 0 waits
    send(3, 8'h31, 1'b0);
    send(3, 8'h32, 1'b0);
    send(3, 8'h33, 1'b1);
    send(0, 8'h01, 1'b1);
    step();
    step();
    check("t4_grant", grant, 4'b1000);
    en[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_grant_held", grant, 4'b1000);
      check("t4_tx_valid", tx_valid, 0);
      check("t4_rdy0", req_ready[0], 0);
    end
    en[3] = 1'b1;
    drain(30);

    // Asynchronous reset mid-packet; requester 0 first afterwards
    send(2, 8'h51, 1'b0);
    send(2, 8'h52, 1'b0);
    send(2, 8'h53, 1'b1);
    send(0, 8'h61, 1'b0);
    send(0, 8'h62, 1'b1);
    step();
    step();
    check("t5_grant", grant, 4'b0100);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_grant", grant, 0);
    check("t5_rst_tx_valid", tx_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_req_ready", req_ready, 0);
    exp_q.delete();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    acc        = '0;
    bubble_due = 1'b0;
    send(0, 8'h61, 1'b0);
    send(0, 8'h62, 1'b1);
    send(2, 8'h71, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drain(30);

    // Random lengths and random tx_ready, one packet per requester: 3,0,1,2
    rnd_ready = 1'b1;
    for (int j = 0; j < NR; j++) begin
      r   = (3 + j) % NR;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) send(r, 8'($urandom_range(0, 255)), (b == len - 1));
    end
    drain(200);
    rnd_ready = 1'b0;

`ifdef UART_ARB_TIMEOUT_EN
    // Stalled owner loses its lock after TIMEOUT idle cycles
    send(3, 8'h90, 1'b0);
    send(0, 8'hA5, 1'b1);
    src_q[3].push_back({1'b1, 8'h91});
    step();
    step();
    check("to_grant", grant, 4'b1000);
    en[3] = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!timeout_pulse && k < 20);
    check("to_delay", k, 6);
    step();
    check("to_pulse_once", timeout_pulse, 0);
    check("to_idle", busy, 0);
    step();
    check("to_regrant", grant, 4'b0001);
    src_q[3].delete();
    en[3] = 1'b1;
    drain(20);
`else
    k = 0;
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
